game_timer: RTL and testbench
=============================

GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 Parameter START_TIME, default 8'h99, two-digit BCD countdown value loaded at game start.
REQ-002 Parameter START_LIVES, default 3'd3, lives loaded at game start.
REQ-003 clk  input  1  system clock, same clock that drives the slow_clock/slow_life generator.
REQ-004 RST  input  1  reset; synchronous, active-high.
REQ-005 slow_clock  input  1  game-step toggle from the divider; every level change is one step event.
REQ-006 slow_life  input  1  countdown toggle from the divider; every level change is one countdown event.
REQ-007 start  input  1  start/restart request; acted on at its rising edge only.
REQ-008 pause  input  1  level; high requests pause.
REQ-009 hit  input  1  player-hit request; acted on at its rising edge only.
REQ-010 tick  output  1  one-cycle game-step strobe, asserted only while running.
REQ-011 lives  output  3  remaining lives.
REQ-012 time_bcd  output  8  remaining time, BCD {tens, ones}.
REQ-013 state  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 OVER.
REQ-014 game_over  output  1  high exactly while state is OVER.

Function
REQ-015 slow_clock and slow_life are synchronous to clk; no synchronizer is used; an event is detected as current value != registered previous value.
REQ-016 start and hit are rising-edge detected against registered previous values; holding either high produces one event.
REQ-017 All outputs are registered; an input event sampled at edge k takes effect in the outputs after edge k (1-cycle latency).
REQ-018 IDLE: start event -> RUN; time_bcd <= START_TIME and lives <= START_LIVES on the same edge; all other events ignored.
REQ-019 RUN: pause high -> PAUSE; pause has priority over slow_clock, slow_life and hit events on that edge, which are discarded.
REQ-020 RUN: each slow_clock event asserts tick for exactly one cycle; tick is never asserted in any other state.
REQ-021 RUN: each slow_life event decrements time_bcd by one in BCD (ones 0 -> 9 with tens borrow; e.g. 8'h40 -> 8'h39).
REQ-022 RUN: each hit event decrements lives by one; lives never wraps below 0.
REQ-023 RUN: if the decrement makes time_bcd 8'h00 or lives 0, state becomes OVER on that same edge.
REQ-024 RUN: simultaneous slow_life and hit events are both applied on the same edge; OVER if either result reaches zero.
REQ-025 RUN: start events are ignored.
REQ-026 PAUSE: pause low -> RUN on the next edge; slow_clock, slow_life and hit events are discarded, never queued; time_bcd and lives hold.
REQ-027 OVER: time_bcd and lives hold their final values; start event -> RUN with the reload of REQ-018; all other inputs ignored.
REQ-028 state value 11 is OVER; no unreachable encodings exist.

Reset
REQ-029 RST high at an edge: state <= IDLE, tick <= 0, game_over <= 0, time_bcd <= START_TIME, lives <= START_LIVES, regardless of current state.
REQ-030 During reset, the edge-detect previous registers load the current slow_clock, slow_life, start and hit values, so the first cycle after reset never produces a spurious event.
REQ-031 Reset asserted mid-game (RUN or PAUSE) abandons the game; a new start event is needed to run.

Verification
REQ-032 Reset, start pulse, then 3 slow_clock toggles -> state 01; exactly 3 single-cycle tick pulses, each 1 cycle after its toggle; time_bcd 8'h99 unchanged.
REQ-033 RUN with time_bcd 8'h10, one slow_life toggle -> 8'h09; with time_bcd 8'h01, one toggle -> 8'h00, state 11 and game_over 1 on the same edge.
REQ-034 RUN with lives 3, hit held high for 10 cycles, then 2 more hit pulses -> lives 2, 1, 0; state 11 when lives reaches 0; no further change.
REQ-035 RUN, pause high for 100 cycles spanning 2 slow_clock and 2 slow_life toggles -> no tick, time_bcd and lives unchanged; pause low -> state 01 next edge.
REQ-036 RUN with time 8'h01 and lives 1, hit and slow_life events on the same edge -> time 8'h00, lives 0, state 11.
REQ-037 RST asserted during RUN with slow_life=1 -> IDLE, time 8'h99, lives 3; the first post-reset cycle gives no event; OVER followed by a start pulse gives state 01 with a reload.

Source files
------------

// File: rtl/game_timer.sv
// Game timer: BCD countdown, lives counter and run/pause/over control
// driven by divider toggles and edge-detected player inputs.
module game_timer #(
  parameter logic [7:0] START_TIME  = 8'h99,
  parameter logic [2:0] START_LIVES = 3'd3
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       slow_clock,
  input  logic       slow_life,
  input  logic       start,
  input  logic       pause,
  input  logic       hit,
  output logic       tick,
  output logic [2:0] lives,
  output logic [7:0] time_bcd,
  output logic [1:0] state,
  output logic       game_over
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_tick;
  logic       r_over;
  logic [2:0] r_lives;
  logic [7:0] r_time;

  logic       r_sc_prev;
  logic       r_sl_prev;
  logic       r_st_prev;
  logic       r_hit_prev;

  logic       w_sc_ev;
  logic       w_sl_ev;
  logic       w_st_ev;
  logic       w_hit_ev;

  logic [7:0] w_time_dec;
  logic [7:0] w_time;
  logic [2:0] w_lives;
  logic       w_tick;

  // Divider outputs toggle: any level change is an event.
  assign w_sc_ev  = slow_clock ^ r_sc_prev;
  assign w_sl_ev  = slow_life ^ r_sl_prev;
  assign w_st_ev  = start & ~r_st_prev;
  assign w_hit_ev = hit & ~r_hit_prev;

  always_comb begin
    w_time_dec = r_time;
    if (r_time != 8'h00) begin
      if (r_time[3:0] == 4'd0)
        w_time_dec = {r_time[7:4] - 4'd1, 4'd9};
      else
        w_time_dec = {r_time[7:4], r_time[3:0] - 4'd1};
    end
  end

  always_comb begin
    w_next  = r_state;
    w_time  = r_time;
    w_lives = r_lives;
    w_tick  = 1'b0;
    unique case (r_state)
      S_IDLE, S_OVER: begin
        if (w_st_ev) begin
          w_next  = S_RUN;
          w_time  = START_TIME;
          w_lives = START_LIVES;
        end
      end
      S_RUN: begin
        if (pause) begin
          w_next = S_PAUSE;
        end else begin
          w_tick = w_sc_ev;
          if (w_sl_ev)
            w_time = w_time_dec;
          if (w_hit_ev && r_lives != 3'd0)
            w_lives = r_lives - 3'd1;
          if ((w_sl_ev && w_time_dec == 8'h00) ||
              (w_hit_ev && r_lives <= 3'd1))
            w_next = S_OVER;
        end
      end
      S_PAUSE: begin
        if (!pause)
          w_next = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    r_sc_prev  <= slow_clock;
    r_sl_prev  <= slow_life;
    r_st_prev  <= start;
    r_hit_prev <= hit;
    if (RST) begin
      r_state <= S_IDLE;
      r_tick  <= 1'b0;
      r_over  <= 1'b0;
      r_time  <= START_TIME;
      r_lives <= START_LIVES;
    end else begin
      r_state <= w_next;
      r_tick  <= w_tick;
      r_over  <= (w_next == S_OVER);
      r_time  <= w_time;
      r_lives <= w_lives;
    end
  end

  assign tick      = r_tick;
  assign lives     = r_lives;
  assign time_bcd  = r_time;
  assign state     = r_state;
  assign game_over = r_over;

endmodule

// File: tb/tb_game_timer.sv
// Self-checking bench for game_timer: directed scenarios plus
// randomized traffic against a decimal-arithmetic reference model.
module tb_game_timer;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       slow_clock = 1'b0;
  logic       slow_life = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       hit = 1'b0;
  logic       tick;
  logic [2:0] lives;
  logic [7:0] time_bcd;
  logic [1:0] state;
  logic       game_over;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: time kept as a plain decimal integer.
  int m_state;
  int m_time;
  int m_lives;
  bit m_tick;
  bit p_sc, p_sl, p_st, p_hit;

  always #5 clk = ~clk;

  game_timer dut (
    .clk        (clk),
    .RST        (RST),
    .slow_clock (slow_clock),
    .slow_life  (slow_life),
    .start      (start),
    .pause      (pause),
    .hit        (hit),
    .tick       (tick),
    .lives      (lives),
    .time_bcd   (time_bcd),
    .state      (state),
    .game_over  (game_over)
  );

  function automatic logic [7:0] bcd(int t);
    logic [7:0] b;
    b[7:4] = 4'(t / 10);
    b[3:0] = 4'(t % 10);
    return b;
  endfunction

  task automatic model_edge();
    bit sc_ev, sl_ev, st_ev, hit_ev;
    sc_ev  = (slow_clock != p_sc);
    sl_ev  = (slow_life != p_sl);
    st_ev  = start && !p_st;
    hit_ev = hit && !p_hit;
    if (RST) begin
      m_state = 0;
      m_time  = 99;
      m_lives = 3;
      m_tick  = 0;
    end else begin
      m_tick = 0;
      case (m_state)
        0, 3: if (st_ev) begin
          m_state = 1;
          m_time  = 99;
          m_lives = 3;
        end
        1: if (pause) m_state = 2;
        else begin
          m_tick = sc_ev;
          if (sl_ev && m_time > 0) m_time--;
          if (hit_ev && m_lives > 0) m_lives--;
          if ((sl_ev && m_time == 0) || (hit_ev && m_lives == 0))
            m_state = 3;
        end
        default: if (!pause) m_state = 1;
      endcase
    end
    p_sc  = slow_clock;
    p_sl  = slow_life;
    p_st  = start;
    p_hit = hit;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
    step();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    slow_clock = 1'($urandom);
    slow_life = 1'($urandom);
    start = 1'($urandom);
    hit = 1'($urandom);
    pause = 1'b0;
    step();
    step();
    n_checks++;
    if (state !== 2'b00) begin
      n_fail++; $display("FAIL reset_state got %0h want 0", state);
    end
    n_checks++;
    if (time_bcd !== 8'h99) begin
      n_fail++; $display("FAIL reset_time got %0h want 99", time_bcd);
    end
    n_checks++;
    if (lives !== 3'd3) begin
      n_fail++; $display("FAIL reset_lives got %0d want 3", lives);
    end
    n_checks++;
    if (tick !== 1'b0 || game_over !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got tick=%b go=%b want 0 0", tick, game_over);
    end
    RST = 1'b0;
    step();
    n_checks++;
    if (state !== 2'b00 || tick !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_event got state=%0h tick=%b want 0 0", state, tick);
    end
    start = 1'b0;
    hit = 1'b0;
    step();
  endtask

  task automatic test_tick();
    int ticks = 0;
    do_reset();
    do_start();
    n_checks++;
    if (state !== 2'b01) begin
      n_fail++; $display("FAIL start_run got %0h want 1", state);
    end
    for (int i = 0; i < 3; i++) begin
      slow_clock = ~slow_clock;
      step();
      ticks += int'(tick);
      n_checks++;
      if (tick !== 1'b1) begin
        n_fail++; $display("FAIL tick_after_toggle got %b want 1", tick);
      end
      step();
      ticks += int'(tick);
      step();
      ticks += int'(tick);
    end
    n_checks++;
    if (ticks != 3) begin
      n_fail++; $display("FAIL tick_count got %0d want 3", ticks);
    end
    n_checks++;
    if (state !== 2'b01 || time_bcd !== 8'h99) begin
      n_fail++;
      $display("FAIL tick_hold got state=%0h time=%0h want 1 99", state, time_bcd);
    end
  endtask

  task automatic test_time();
    do_reset();
    do_start();
    for (int k = 1; k <= 99; k++) begin
      slow_life = ~slow_life;
      step();
      n_checks++;
      if (time_bcd !== bcd(99 - k)) begin
        n_fail++;
        $display("FAIL time_dec k=%0d got %0h want %0h", k, time_bcd, bcd(99 - k));
      end
      if (k == 60) begin
        n_checks++;
        if (time_bcd !== 8'h39) begin
          n_fail++; $display("FAIL time_borrow got %0h want 39", time_bcd);
        end
      end
      if (k == 90) begin
        n_checks++;
        if (time_bcd !== 8'h09) begin
          n_fail++; $display("FAIL time_10_to_09 got %0h want 09", time_bcd);
        end
      end
      if (k < 99) begin
        n_checks++;
        if (state !== 2'b01) begin
          n_fail++; $display("FAIL time_run k=%0d got %0h want 1", k, state);
        end
      end
    end
    n_checks++;
    if (state !== 2'b11 || game_over !== 1'b1) begin
      n_fail++;
      $display("FAIL time_over got state=%0h go=%b want 3 1", state, game_over);
    end
    slow_life = ~slow_life;
    step();
    n_checks++;
    if (time_bcd !== 8'h00 || state !== 2'b11) begin
      n_fail++;
      $display("FAIL over_hold_time got time=%0h state=%0h want 00 3", time_bcd, state);
    end
  endtask

  task automatic test_hits();
    do_reset();
    do_start();
    hit = 1'b1;
    repeat (10) step();
    hit = 1'b0;
    step();
    n_checks++;
    if (lives !== 3'd2 || state !== 2'b01) begin
      n_fail++;
      $display("FAIL hit_held got lives=%0d state=%0h want 2 1", lives, state);
    end
    hit = 1'b1; step(); hit = 1'b0; step();
    n_checks++;
    if (lives !== 3'd1) begin
      n_fail++; $display("FAIL hit_pulse got %0d want 1", lives);
    end
    hit = 1'b1; step();
    n_checks++;
    if (lives !== 3'd0 || state !== 2'b11 || game_over !== 1'b1) begin
      n_fail++;
      $display("FAIL hit_over got lives=%0d state=%0h go=%b want 0 3 1",
               lives, state, game_over);
    end
    hit = 1'b0; step(); hit = 1'b1; step(); hit = 1'b0; step();
    n_checks++;
    if (lives !== 3'd0 || state !== 2'b11) begin
      n_fail++;
      $display("FAIL hit_no_wrap got lives=%0d state=%0h want 0 3", lives, state);
    end
  endtask

  task automatic test_pause();
    int ticks = 0;
    do_reset();
    do_start();
    slow_life = ~slow_life;
    step();
    pause = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i == 20 || i == 50) slow_clock = ~slow_clock;
      if (i == 30 || i == 70) slow_life = ~slow_life;
      if (i == 40) hit = 1'b1;
      if (i == 41) hit = 1'b0;
      step();
      ticks += int'(tick);
    end
    n_checks++;
    if (ticks != 0) begin
      n_fail++; $display("FAIL pause_tick got %0d want 0", ticks);
    end
    n_checks++;
    if (state !== 2'b10 || time_bcd !== 8'h98 || lives !== 3'd3) begin
      n_fail++;
      $display("FAIL pause_hold got state=%0h time=%0h lives=%0d want 2 98 3",
               state, time_bcd, lives);
    end
    pause = 1'b0;
    step();
    n_checks++;
    if (state !== 2'b01) begin
      n_fail++; $display("FAIL pause_resume got %0h want 1", state);
    end
    step();
    n_checks++;
    if (tick !== 1'b0 || time_bcd !== 8'h98) begin
      n_fail++;
      $display("FAIL pause_no_queue got tick=%b time=%0h want 0 98", tick, time_bcd);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    do_start();
    repeat (2) begin
      hit = 1'b1; step(); hit = 1'b0; step();
    end
    repeat (98) begin
      slow_life = ~slow_life; step();
    end
    n_checks++;
    if (time_bcd !== 8'h01 || lives !== 3'd1) begin
      n_fail++;
      $display("FAIL simul_setup got time=%0h lives=%0d want 01 1", time_bcd, lives);
    end
    hit = 1'b1;
    slow_life = ~slow_life;
    step();
    hit = 1'b0;
    n_checks++;
    if (time_bcd !== 8'h00 || lives !== 3'd0 || state !== 2'b11) begin
      n_fail++;
      $display("FAIL simul_both got time=%0h lives=%0d state=%0h want 00 0 3",
               time_bcd, lives, state);
    end
  endtask

  task automatic test_reset_midgame();
    do_reset();
    do_start();
    repeat (3) begin
      slow_life = ~slow_life; step();
    end
    if (slow_life) begin
      slow_clock = ~slow_clock; step();
      slow_life = 1'b0; step();
    end
    RST = 1'b1;
    slow_life = 1'b1;
    step();
    n_checks++;
    if (state !== 2'b00 || time_bcd !== 8'h99 || lives !== 3'd3) begin
      n_fail++;
      $display("FAIL midgame_reset got state=%0h time=%0h lives=%0d want 0 99 3",
               state, time_bcd, lives);
    end
    RST = 1'b0;
    step();
    n_checks++;
    if (state !== 2'b00 || tick !== 1'b0) begin
      n_fail++;
      $display("FAIL midgame_post got state=%0h tick=%b want 0 0", state, tick);
    end
    do_start();
    n_checks++;
    if (state !== 2'b01 || time_bcd !== 8'h99) begin
      n_fail++;
      $display("FAIL midgame_start got state=%0h time=%0h want 1 99", state, time_bcd);
    end
    repeat (3) begin
      slow_life = ~slow_life; step();
    end
    repeat (3) begin
      hit = 1'b1; step(); hit = 1'b0; step();
    end
    n_checks++;
    if (state !== 2'b11 || time_bcd !== 8'h96 || lives !== 3'd0) begin
      n_fail++;
      $display("FAIL midgame_over got state=%0h time=%0h lives=%0d want 3 96 0",
               state, time_bcd, lives);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (state !== 2'b01 || time_bcd !== 8'h99 || lives !== 3'd3 || game_over !== 1'b0) begin
      n_fail++;
      $display("FAIL over_restart got state=%0h time=%0h lives=%0d go=%b want 1 99 3 0",
               state, time_bcd, lives, game_over);
    end
  endtask

  task automatic test_random();
    logic [14:0] got, want;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(99) < 30) slow_clock = ~slow_clock;
      if ($urandom_range(99) < 25) slow_life = ~slow_life;
      start = ($urandom_range(99) < 8);
      hit   = ($urandom_range(99) < 12);
      pause = ($urandom_range(99) < 10);
      RST   = ($urandom_range(999) < 4);
      step();
      got  = {state, time_bcd, lives, tick, game_over};
      want = {2'(m_state), bcd(m_time), 3'(m_lives), m_tick, m_state == 3};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL random cyc=%0d got %h want %h", i, got, want);
      end
    end
    RST = 1'b0;
    pause = 1'b0;
    start = 1'b0;
    hit = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tick();
    test_time();
    test_hits();
    test_pause();
    test_simultaneous();
    test_reset_midgame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
